// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file / pending-write scoreboard.
package regfile_pkg;
   localparam int XLEN_DEF   = 32;
   localparam int NREGS_DEF  = 32;
   localparam int PEND_W_DEF = 2;

   typedef logic [PEND_W_DEF-1:0] pend_cnt_t;
   localparam pend_cnt_t PEND_MAX = '1;

   function automatic int aw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Saturating up/down pending-write counter for one register; clr wins over inc/dec.
module pend_counter #(
   parameter int W = regfile_pkg::PEND_W_DEF
) (
   input  logic         WrClk,
   input  logic         Reset,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o,
   output logic         nonzero_o,
   output logic         full_o
);
   logic [W-1:0] cnt_q, cnt_d;
   logic         do_inc, do_dec;

   assign nonzero_o = (cnt_q != '0);
   assign full_o    = (cnt_q == '1);
   assign cnt_o     = cnt_q;

   // A write-back with nothing outstanding is legal and leaves the count at zero.
   assign do_inc = inc_i && !full_o;
   assign do_dec = dec_i && nonzero_o;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                 cnt_d = '0;
      else if (do_inc && !do_dec) cnt_d = cnt_q + W'(1);
      else if (do_dec && !do_inc) cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge WrClk or posedge Reset) begin
      if (Reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NRD combinational read ports, write-back bypass and a
// per-register pending-write scoreboard for RAW hazard detection. Reg 0 is zero.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NRD    = 2,
   parameter int PEND_W = PEND_W_DEF,
   localparam int AW    = aw(NREGS)
) (
   input  logic                WrClk,
   input  logic                Reset,
   input  logic [NRD*AW-1:0]   Ra,
   output logic [NRD*XLEN-1:0] busOut,
   output logic [NRD-1:0]      RdBusy,
   input  logic [AW-1:0]       Rw,
   input  logic                RegWr,
   input  logic [XLEN-1:0]     busW,
   input  logic [AW-1:0]       Rs,
   input  logic                RsvValid,
   output logic                RsvFull,
   input  logic                Flush,
   output logic                PendAny
);
   logic [XLEN-1:0]              regs_q [NREGS];
   logic [NREGS-1:0][PEND_W-1:0] cnt;
   logic [NREGS-1:0]             nz, full;
   logic                         wr_en, rsv_ok;

   assign wr_en   = RegWr && (Rw != '0);
   assign RsvFull = RsvValid && (Rs != '0) && full[Rs];
   assign rsv_ok  = RsvValid && (Rs != '0) && !RsvFull;
   assign PendAny = |nz;

   always_ff @(posedge WrClk or posedge Reset) begin
      if (Reset) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      end else if (wr_en) begin
         regs_q[Rw] <= busW;
      end
   end

   assign cnt[0]  = '0;
   assign nz[0]   = 1'b0;
   assign full[0] = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      localparam logic [AW-1:0] IDX = AW'(r);
      pend_counter #(.W(PEND_W)) u_cnt (
         .WrClk     (WrClk),
         .Reset     (Reset),
         .inc_i     (rsv_ok && (Rs == IDX)),
         .dec_i     (RegWr && (Rw == IDX)),
         .clr_i     (Flush),
         .cnt_o     (cnt[r]),
         .nonzero_o (nz[r]),
         .full_o    (full[r])
      );
   end

   // The last outstanding write landing this cycle is served by the bypass, so not busy.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          byp;
      assign ra  = Ra[i*AW +: AW];
      assign byp = wr_en && (Rw == ra);
      assign busOut[i*XLEN +: XLEN] = (ra == '0) ? '0 : (byp ? busW : regs_q[ra]);
      assign RdBusy[i] = (ra != '0) && nz[ra] &&
                         !((cnt[ra] == PEND_W'(1)) && RegWr && (Rw == ra));
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;
   logic        WrClk = 1'b0;
   logic        Reset;
   logic [9:0]  Ra;
   logic [63:0] busOut;
   logic [1:0]  RdBusy;
   logic [4:0]  Rw, Rs;
   logic        RegWr, RsvValid, RsvFull, Flush, PendAny;
   logic [31:0] busW;
   int          vecs = 0;
   int          errs = 0;

   regfile_scoreboard dut (
      .WrClk(WrClk), .Reset(Reset), .Ra(Ra), .busOut(busOut), .RdBusy(RdBusy),
      .Rw(Rw), .RegWr(RegWr), .busW(busW), .Rs(Rs), .RsvValid(RsvValid),
      .RsvFull(RsvFull), .Flush(Flush), .PendAny(PendAny)
   );

   always #5 WrClk = ~WrClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge WrClk);
      #1;
   endtask

   task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
      Ra = {a1, a0};
   endtask

   initial begin
      Reset = 1'b1; RegWr = 0; RsvValid = 0; Flush = 0;
      Rw = 0; Rs = 0; busW = 0;
      set_ra(5, 0);
      // 1: reset state
      #3;
      chk("rst_bus0", busOut[31:0], 32'h0);
      chk("rst_bus1", busOut[63:32], 32'h0);
      chk("rst_busy", {30'd0, RdBusy}, 32'h0);
      chk("rst_pend", {31'd0, PendAny}, 32'h0);
      tick();
      Reset = 1'b0;

      // 2: bypass, persistence, reg 0 writes dropped
      RegWr = 1; Rw = 5; busW = 32'hDEADBEEF; set_ra(5, 0);
      #1 chk("byp_same", busOut[31:0], 32'hDEADBEEF);
      tick(); RegWr = 0; busW = 0;
      #1 chk("wr_hold", busOut[31:0], 32'hDEADBEEF);
      RegWr = 1; Rw = 0; busW = 32'h1; set_ra(0, 0);
      #1 chk("r0_byp", busOut[31:0], 32'h0);
      tick(); RegWr = 0;
      #1 chk("r0_read", busOut[63:32], 32'h0);

      // 3: reserve, busy next cycle, cleared by write-back
      RsvValid = 1; Rs = 7; set_ra(7, 5);
      #1 chk("rsv_busy_now", {31'd0, RdBusy[0]}, 32'h0);
      tick(); RsvValid = 0;
      #1 chk("rsv_busy_nxt", {31'd0, RdBusy[0]}, 32'h1);
      chk("rsv_pend", {31'd0, PendAny}, 32'h1);
      RegWr = 1; Rw = 7; busW = 32'h1234;
      #1 chk("wb_busy_clr", {31'd0, RdBusy[0]}, 32'h0);
      chk("wb_byp", busOut[31:0], 32'h1234);
      tick(); RegWr = 0;
      #1 chk("wb_pend", {31'd0, PendAny}, 32'h0);
      chk("wb_data", busOut[31:0], 32'h1234);
      chk("wb_other", busOut[63:32], 32'hDEADBEEF);

      // 4: saturation and simultaneous reserve + write-back
      RsvValid = 1; Rs = 3;
      #1 chk("sat_full0", {31'd0, RsvFull}, 32'h0);
      tick(); tick();
      #1 chk("sat_full2", {31'd0, RsvFull}, 32'h0);
      tick();
      #1 chk("sat_full3", {31'd0, RsvFull}, 32'h1);
      tick();
      #1 chk("sat_hold", {31'd0, RsvFull}, 32'h1);
      RsvValid = 0; set_ra(3, 0); RegWr = 1; Rw = 3; busW = 32'hA;
      #1 chk("cnt3_wb_busy", {31'd0, RdBusy[0]}, 32'h1);
      tick();
      RsvValid = 1; Rs = 3;
      #1 chk("cnt2_full", {31'd0, RsvFull}, 32'h0);
      tick(); RegWr = 0;
      #1 chk("incdec_full", {31'd0, RsvFull}, 32'h0);
      tick();
      #1 chk("incdec_cnt3", {31'd0, RsvFull}, 32'h1);
      RsvValid = 0; Flush = 1;
      tick(); Flush = 0;
      #1 chk("flush_pend", {31'd0, PendAny}, 32'h0);

      // 5: flush overrides reserve and decrement, write still lands
      RsvValid = 1; Rs = 9;
      tick(); tick();
      Rs = 4;
      tick(); RsvValid = 0;
      #1 chk("pre_flush_pend", {31'd0, PendAny}, 32'h1);
      Flush = 1; RsvValid = 1; Rs = 9; RegWr = 1; Rw = 4; busW = 32'h55;
      tick(); Flush = 0; RsvValid = 0; RegWr = 0; set_ra(9, 4);
      #1 chk("fl_pend", {31'd0, PendAny}, 32'h0);
      chk("fl_busy", {30'd0, RdBusy}, 32'h0);
      chk("fl_reg4", busOut[63:32], 32'h55);

      // 6: asynchronous reset mid-cycle
      RegWr = 1; Rw = 2; busW = 32'h10;
      tick(); RegWr = 0; RsvValid = 1; Rs = 2;
      tick(); RsvValid = 0; set_ra(2, 4);
      #1 chk("pre_rst_busy", {31'd0, RdBusy[0]}, 32'h1);
      chk("pre_rst_data", busOut[31:0], 32'h10);
      #1 Reset = 1'b1;
      #1 chk("arst_bus0", busOut[31:0], 32'h0);
      chk("arst_bus1", busOut[63:32], 32'h0);
      chk("arst_busy", {30'd0, RdBusy}, 32'h0);
      chk("arst_pend", {31'd0, PendAny}, 32'h0);
      tick(); Reset = 1'b0;
      #1 chk("post_rst_bus", busOut[31:0], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
